usb_rx_pkt: RTL
===============

# usb_rx_pkt

Receive-side packet engine for the USB link, the counterpart of the transmit FSM that drives `tx_valid`/`tx_ready`. It takes a UTMI-style byte stream and decodes the PID, then forwards the payload bytes. It also strips and checks the CRC16 and reports one status strobe per packet. It sits between the PHY receive interface and the endpoint buffer logic.

## Interface
- `MAX_LEN`, default 64: maximum payload bytes per data packet, excluding PID and CRC; range 1..255.
- `clk` input, 1: single clock; everything is on its rising edge.
- `reset` input, 1: synchronous, active-low.
- `rx_active` input, 1: high for the duration of a packet.
- `rx_valid` input, 1: `rx_data` holds a valid byte this cycle (only meaningful while `rx_active`=1).
- `rx_data` input, 8: received byte, bit 0 first on the wire.
- `rx_error` input, 1: PHY error (bit stuff or similar) during the current packet.
- `pid_out` output, 4: decoded PID of the current or last packet.
- `pid_valid` output, 1: one-cycle pulse when the PID byte is accepted.
- `data_out` output, 8: payload byte.
- `data_valid` output, 1: one-cycle pulse per payload byte.
- `pkt_done` output, 1: one-cycle pulse at end of every packet.
- `pkt_ok` output, 1: packet good (held from `pkt_done` until next packet start).
- `pid_err`, `len_err`, `rx_err` outputs, 1 each: error flags, held like `pkt_ok`.
- `byte_cnt` output, 8: payload length, held like `pkt_ok`.

## Operation
- Reset state: all outputs 0; FSM in IDLE; CRC register set to 16'hFFFF.
- `rx_active_q` resets to 1. A new packet needs a sampled 0→1 edge, so a packet already in progress at reset release is ignored entirely.
- FSM states: IDLE, PID, DATA, ERR.
- IDLE → PID on a `rx_active` rising edge.
  - On that transition, clear all held flags and `byte_cnt`.
  - Set CRC to 16'hFFFF.
  - Clear the 2-byte hold-back.
- PID state, first `rx_valid` byte:
  - If `rx_data[7:4]` != ~`rx_data[3:0]`, raise `pid_err` and go to ERR.
  - Data PIDs 0x3, 0xB, 0x7, 0xF go to DATA.
  - Handshake PIDs 0x2, 0xA, 0xE, 0x6 go to DATA with "no payload" set.
  - Any other PID raises `pid_err` and goes to ERR.
  - `pid_out` is loaded and `pid_valid` pulses for every byte with a valid complement, including unsupported PIDs.
- DATA state, data PID:
  - Every byte updates the CRC with a reflected shift: per bit, fb=crc[0]^d; crc=crc>>1; if fb, crc^=16'hA001; bits are taken LSB first.
  - Bytes enter a 2-deep hold-back. A byte is emitted on `data_out` only once two later bytes have arrived, so the trailing CRC bytes are never forwarded.
  - `byte_cnt` increments per emitted byte.
  - Reaching MAX_LEN+3 bytes after the PID raises `len_err` and goes to ERR.
- DATA state, handshake PID: any byte after the PID raises `len_err` and goes to ERR.
- `rx_error`=1 while `rx_active`=1, in any non-IDLE state, raises `rx_err` and goes to ERR.
- End of packet is `rx_active` sampled 0 in PID, DATA, or ERR:
  - `pkt_done` pulses once and the FSM returns to IDLE.
  - Ending in PID (no PID byte received) sets `len_err`.
  - A data PID with fewer than 2 post-PID bytes sets `len_err`.
  - A data PID with a final CRC != 16'hB001 leaves `pkt_ok`=0; no separate CRC flag exists.
  - `pkt_ok` = no error flag set AND (handshake OR CRC residual == 16'hB001).
  - Hold-back contents are discarded.
- ERR state: ignores bytes and emits no `data_valid`; it waits for `rx_active`=0.
- `rx_active` and `rx_error` in the same cycle: the error is recorded first, and `pkt_done` follows on the next low sample.

## Timing
- All outputs are registered.
- `pid_valid` asserts 1 cycle after the PID byte's `rx_valid`.
- The Nth payload byte appears on `data_out` with `data_valid` 1 cycle after the `rx_valid` of byte N+2.
- `pkt_done` asserts 1 cycle after the first cycle `rx_active` is sampled 0.
- Flags and `byte_cnt` are valid in the `pkt_done` cycle and held until the next packet start.
- Back-to-back packets: `rx_active` may rise 1 cycle after `pkt_done`, and the block accepts it.
- `rx_valid` may be asserted every cycle, with no throughput limit. Gaps between bytes are allowed.

## Test plan
- **Reset:** hold `reset`=0 with random inputs → all outputs 0. Release `reset` mid-packet (`rx_active`=1) → no `pid_valid`, no `data_valid`, no `pkt_done` until the next rising edge of `rx_active`.
- **Zero-length DATA0:** bytes 0xC3, 0x00, 0x00 → `pid_out`=0x3, no `data_valid`, `pkt_done` with `pkt_ok`=1, `byte_cnt`=0.
- **Corrupt CRC:** same packet with bytes 0xC3, 0x00, 0x01 → `pkt_ok`=0, all error flags 0. Then DATA1 0x4B with bytes 0xAA 0x55 plus corrupt CRC → exactly 0xAA, 0x55 emitted with 1-cycle spacing when input is back-to-back; `byte_cnt`=2.
- **ACK and PID errors:** 0xD2 alone → `pid_out`=0x2, `pkt_ok`=1. 0xD2 followed by 0x00 → `len_err`=1. PID byte 0xC4 → `pid_err`=1, `pid_valid` stays 0.
- **Length limits:**
  - With `MAX_LEN`=4, DATA0 plus 7 bytes → `len_err` and exactly 4 `data_valid` pulses.
  - PID only followed by end of packet → `len_err`.
  - `rx_active` pulse with no bytes → `len_err`.
- **`rx_error` mid-payload:** assert `rx_error` during the payload → `data_valid` stops, `rx_err`=1, `pkt_ok`=0, and a single `pkt_done`. A following valid packet 1 cycle later is received cleanly.

Source files
------------

// File: rtl/usb_rx_pkt_if.sv
// PHY receive strobes in, decoded packet results out.
// Handshake: rx_data is consumed on every clock edge where rx_active and
// rx_valid are both high; there is no ready/backpressure toward the PHY.
// Downstream pulses (pid_valid, data_valid, pkt_done) last one cycle each and
// cannot be stalled.
interface usb_rx_pkt_if;
  logic       rx_active;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_error;
  logic [3:0] pid_out;
  logic       pid_valid;
  logic [7:0] data_out;
  logic       data_valid;
  logic       pkt_done;
  logic       pkt_ok;
  logic       pid_err;
  logic       len_err;
  logic       rx_err;
  logic [7:0] byte_cnt;

  // PHY/driver side
  modport master (
    output rx_active, rx_valid, rx_data, rx_error,
    input  pid_out, pid_valid, data_out, data_valid, pkt_done, pkt_ok,
           pid_err, len_err, rx_err, byte_cnt
  );

  // Packet engine side
  modport slave (
    input  rx_active, rx_valid, rx_data, rx_error,
    output pid_out, pid_valid, data_out, data_valid, pkt_done, pkt_ok,
           pid_err, len_err, rx_err, byte_cnt
  );
endinterface

// File: rtl/usb_rx_pkt.sv
// USB receive packet engine: PID decode, payload forwarding through a
// 2-byte hold-back (so the trailing CRC16 is never forwarded), CRC16 check
// and one status strobe per packet.
module usb_rx_pkt #(
  parameter int MAX_LEN = 64
) (
  input  logic          clk,
  input  logic          reset,
  usb_rx_pkt_if.slave   bus,
  output logic [1:0]    fsm_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, PID = 2'd1, DATA = 2'd2, ERR = 2'd3} state_t;

  // Post-PID byte count at which a data packet is over length (payload + 2 CRC).
  localparam logic [8:0] LEN_LIMIT = 9'(MAX_LEN + 2);

  state_t      state;
  logic        rx_active_q;
  logic [15:0] crc;
  logic [7:0]  hold0;
  logic [7:0]  hold1;
  logic [1:0]  hold_cnt;
  logic [8:0]  post_cnt;
  logic        no_payload;
  logic        end_len_err;
  logic        end_ok;

  assign fsm_state = state;

  // Reflected CRC16 (poly 0x8005 reflected = 0xA001), LSB first.
  function automatic logic [15:0] crc_upd(input logic [15:0] c_in, input logic [7:0] d);
    logic [15:0] c;
    logic        fb;
    c = c_in;
    for (int i = 0; i < 8; i++) begin
      fb = c[0] ^ d[i];
      c  = c >> 1;
      if (fb) c = c ^ 16'hA001;
    end
    return c;
  endfunction

  // End-of-packet verdict; too-short data packets and a missing PID count as length errors.
  always_comb begin
    end_len_err = bus.len_err;
    end_ok      = 1'b0;
    if (state == PID) end_len_err = 1'b1;
    if (state == DATA && !no_payload && post_cnt < 9'd2) end_len_err = 1'b1;
    end_ok = !bus.pid_err && !bus.rx_err && !end_len_err &&
             (no_payload || crc == 16'hB001);
  end

  // Packet FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state          <= IDLE;
      rx_active_q    <= 1'b1;
      crc            <= 16'hFFFF;
      hold0          <= 8'd0;
      hold1          <= 8'd0;
      hold_cnt       <= 2'd0;
      post_cnt       <= 9'd0;
      no_payload     <= 1'b0;
      bus.pid_out    <= 4'd0;
      bus.pid_valid  <= 1'b0;
      bus.data_out   <= 8'd0;
      bus.data_valid <= 1'b0;
      bus.pkt_done   <= 1'b0;
      bus.pkt_ok     <= 1'b0;
      bus.pid_err    <= 1'b0;
      bus.len_err    <= 1'b0;
      bus.rx_err     <= 1'b0;
      bus.byte_cnt   <= 8'd0;
    end else begin
      rx_active_q    <= bus.rx_active;
      bus.pid_valid  <= 1'b0;
      bus.data_valid <= 1'b0;
      bus.pkt_done   <= 1'b0;
      if (state == IDLE) begin
        if (bus.rx_active && !rx_active_q) begin
          state        <= PID;
          bus.pkt_ok   <= 1'b0;
          bus.pid_err  <= 1'b0;
          bus.len_err  <= 1'b0;
          bus.rx_err   <= 1'b0;
          bus.byte_cnt <= 8'd0;
          crc          <= 16'hFFFF;
          hold_cnt     <= 2'd0;
          post_cnt     <= 9'd0;
          no_payload   <= 1'b0;
        end
      end else if (!bus.rx_active) begin
        // End of packet: hold-back contents are simply dropped.
        state        <= IDLE;
        bus.pkt_done <= 1'b1;
        bus.len_err  <= end_len_err;
        bus.pkt_ok   <= end_ok;
        hold_cnt     <= 2'd0;
      end else if (bus.rx_error) begin
        state      <= ERR;
        bus.rx_err <= 1'b1;
      end else if (bus.rx_valid) begin
        case (state)
          PID: begin
            if (bus.rx_data[7:4] != ~bus.rx_data[3:0]) begin
              bus.pid_err <= 1'b1;
              state       <= ERR;
            end else begin
              bus.pid_out   <= bus.rx_data[3:0];
              bus.pid_valid <= 1'b1;
              case (bus.rx_data[3:0])
                4'h3, 4'hB, 4'h7, 4'hF: state <= DATA;
                4'h2, 4'hA, 4'hE, 4'h6: begin
                  state      <= DATA;
                  no_payload <= 1'b1;
                end
                default: begin
                  bus.pid_err <= 1'b1;
                  state       <= ERR;
                end
              endcase
            end
          end
          DATA: begin
            if (no_payload || post_cnt == LEN_LIMIT) begin
              bus.len_err <= 1'b1;
              state       <= ERR;
            end else begin
              post_cnt <= post_cnt + 9'd1;
              crc      <= crc_upd(crc, bus.rx_data);
              case (hold_cnt)
                2'd0: begin
                  hold0    <= bus.rx_data;
                  hold_cnt <= 2'd1;
                end
                2'd1: begin
                  hold1    <= bus.rx_data;
                  hold_cnt <= 2'd2;
                end
                default: begin
                  bus.data_out   <= hold0;
                  bus.data_valid <= 1'b1;
                  bus.byte_cnt   <= bus.byte_cnt + 8'd1;
                  hold0          <= hold1;
                  hold1          <= bus.rx_data;
                end
              endcase
            end
          end
          default: ;  // ERR: bytes ignored until rx_active drops
        endcase
      end
    end
  end

endmodule
